alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Command-driven accumulator front end for the 8-bit datapath. It latches operands from the CPU data bus into an accumulator (A) and an operand register (B), and drives the existing `alu` adder. Subtraction is done by complementing B and forcing carry-in. The sum and carry-out are captured back into A and the C/Z/N flags, and the result is returned over a valid/ready response port. It sits between the instruction sequencer and the `alu` adder, which it instantiates.

## Interface
- `WIDTH`, 8, datapath width; only 8 is supported because `alu` is fixed at 8 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  3  opcode: 0 LDA, 1 LDB, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 CLC, 7 STA.
- `cmd_data`  in  8  operand for LDA/LDB; ignored otherwise.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  8  result value.
- `flag_c`, `flag_z`, `flag_n`  out  1 each  carry, zero and negative flags (registered).
- `acc_q`, `breg_q`  out  8 each  current A and B register contents.

## Operation
- States are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE: `cmd_ready`=1. A command is accepted when `cmd_valid`&&`cmd_ready`.
  - LDA: A<=`cmd_data`; Z<=(data==0); N<=data[7]; C is unchanged. Stays in IDLE.
  - LDB: B<=`cmd_data`. Flags are unchanged. Stays in IDLE.
  - CLC: C<=0. Stays in IDLE.
  - STA: `res_data`<=A. Goes to RESP.
  - ADD, ADC, SUB, SBC: the opcode is registered. Goes to EXEC.
- EXEC lasts one cycle. `alu` is driven as `in_a`=A, and:
  - ADD: `in_b`=B, `cin`=0.
  - ADC: `in_b`=B, `cin`=C.
  - SUB: `in_b`=~B, `cin`=1.
  - SBC: `in_b`=~B, `cin`=C.
- At the end of EXEC:
  - A<=`sum`, `res_data`<=`sum`.
  - C<=`cout`; for SUB/SBC, C=1 means no borrow.
  - Z<=(`sum`==0); N<=`sum`[7].
  - Goes to RESP.
- RESP: `res_valid`=1 and `cmd_ready`=0. On `res_valid`&&`res_ready` the block goes to IDLE.
- Arithmetic is modulo 256, with the carry captured only in C; no overflow flag.
- Outside EXEC, the `alu` inputs are A, B and 0, and the outputs are ignored.

## Timing
- Reset values: `cmd_ready`=0 while `reset` is asserted, then 1 in IDLE. `res_valid`=0, `res_data`=0, A=B=0, C=Z=N=0.
- LDA/LDB/CLC: the registers update at the accept edge, and the next command can be accepted the following cycle. Throughput is one per cycle.
- Arithmetic: accepted at edge k; EXEC in cycle k+1; `res_valid`=1 from cycle k+2. Minimum 3 cycles per operation, including the handshake.
- STA: `res_valid`=1 in the cycle after accept.
- Backpressure: while in RESP with `res_ready`=0, `res_data`, the flags, `res_valid` and A/B all hold stable.
- If `res_ready`=1 in the first RESP cycle, the result is taken and `cmd_ready` rises the next cycle. No combinational path from `res_ready` to `cmd_ready`.
- `cmd_valid` while not ready is ignored; the command is not lost, the sender holds it.
- Reset asserted mid-EXEC or mid-RESP: immediate return to IDLE with all reset values. The pending result is discarded.
- The flags are visible on the same edge that A updates.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` constant.
  - `alu_op_e` enum carrying the opcode encoding above.
  - `alu_ctrl_state_e` enum {IDLE, EXEC, RESP}.
- One sub-module: the existing `alu`, instantiated unchanged with ports `in_a`, `in_b`, `cin`, `sum`, `cout`.
- Operand mux, FSM and registers live in `alu_ctrl`.

## Test plan
- LDA 10, LDB 20, ADD -> `res_data`=30, C=0, Z=0, N=0, `res_valid` 2 cycles after the ADD accept.
- LDA 255, LDB 1, ADD -> `res_data`=0, C=1, Z=1, N=0. Then ADC (A=0, B=1, C=1) -> 2, C=0.
- LDA 50, LDB 10, SUB -> 40, C=1. Then LDA 10, LDB 20, SUB -> 246 (0xF6), C=0, N=1.
- CLC, then LDA 100, LDB 155, ADC -> 255, C=0, N=1. STA -> `res_data`=255.
- Backpressure: hold `res_ready`=0 for 3 cycles after ADD -> `res_data` and flags stable, `cmd_ready`=0, and a held `cmd_valid` is not accepted until the response is taken.
- Assert `reset` during EXEC of ADD (A=10, B=20) -> the next cycle has A=B=0, all flags 0, `res_valid`=0, and no stale response after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and encodings for the accumulator front end and its adder.
package alu_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [2:0] {
      OP_LDA = 3'd0,
      OP_LDB = 3'd1,
      OP_ADD = 3'd2,
      OP_ADC = 3'd3,
      OP_SUB = 3'd4,
      OP_SBC = 3'd5,
      OP_CLC = 3'd6,
      OP_STA = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } alu_ctrl_state_e;

endpackage

// File: rtl/alu.sv
// Fixed 8-bit ripple adder with carry in/out.
module alu (
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, in_a} + {1'b0, in_b} + {8'd0, cin};

endmodule

// File: rtl/alu_ctrl.sv
// Command-driven accumulator/operand front end around the adder, with a
// valid/ready result port and registered C/Z/N flags.
module alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic [WIDTH-1:0] acc_q,
   output logic [WIDTH-1:0] breg_q
);
   import alu_pkg::*;

   alu_ctrl_state_e  state, state_nx;
   alu_op_e          op_q, op_in;
   logic [WIDTH-1:0] acc, breg, res_q;
   logic [WIDTH-1:0] alu_b, alu_sum;
   logic             c_q, z_q, n_q;
   logic             alu_cin, alu_cout;
   logic             accept;

   assign op_in  = alu_op_e'(cmd_op);
   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) begin
            case (op_in)
               OP_STA:                        state_nx = RESP;
               OP_ADD, OP_ADC, OP_SUB, OP_SBC: state_nx = EXEC;
               default:                       state_nx = IDLE;
            endcase
         end
         EXEC:    state_nx = RESP;
         RESP:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Subtraction is A + ~B + cin; adder inputs only matter during EXEC.
   always_comb begin
      cmd_ready = (state == IDLE) && !reset;
      res_valid = (state == RESP);
      alu_b     = breg;
      alu_cin   = 1'b0;
      if (state == EXEC) begin
         case (op_q)
            OP_ADC: alu_cin = c_q;
            OP_SUB: begin alu_b = ~breg; alu_cin = 1'b1; end
            OP_SBC: begin alu_b = ~breg; alu_cin = c_q;  end
            default: ;
         endcase
      end
   end

   alu u_alu (
      .in_a (acc),
      .in_b (alu_b),
      .cin  (alu_cin),
      .sum  (alu_sum),
      .cout (alu_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         breg  <= '0;
         res_q <= '0;
         c_q   <= 1'b0;
         z_q   <= 1'b0;
         n_q   <= 1'b0;
         op_q  <= OP_ADD;
      end else if (accept) begin
         case (op_in)
            OP_LDA: begin
               acc <= cmd_data;
               z_q <= (cmd_data == '0);
               n_q <= cmd_data[WIDTH-1];
            end
            OP_LDB:  breg  <= cmd_data;
            OP_CLC:  c_q   <= 1'b0;
            OP_STA:  res_q <= acc;
            default: op_q  <= op_in;
         endcase
      end else if (state == EXEC) begin
         acc   <= alu_sum;
         res_q <= alu_sum;
         c_q   <= alu_cout;
         z_q   <= (alu_sum == '0);
         n_q   <= alu_sum[WIDTH-1];
      end
   end

   assign res_data = res_q;
   assign flag_c   = c_q;
   assign flag_z   = z_q;
   assign flag_n   = n_q;
   assign acc_q    = acc;
   assign breg_q   = breg;

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomised and directed checking of alu_ctrl against a borrow/carry
// arithmetic model of the command set.
module tb_alu_ctrl;

   localparam logic [2:0] LDA = 3'd0, LDB = 3'd1, ADD = 3'd2, ADC = 3'd3,
                          SUB = 3'd4, SBC = 3'd5, CLC = 3'd6, STA = 3'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       res_valid, res_ready = 1'b0;
   logic [7:0] res_data, acc_q, breg_q;
   logic       flag_c, flag_z, flag_n;

   int checks = 0, errors = 0;
   int m_a = 0, m_b = 0, m_c = 0, m_z = 0, m_n = 0, m_res = 0;
   int last_res;

   alu_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
      .acc_q(acc_q), .breg_q(breg_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural effect of a command, in plain carry/borrow arithmetic.
   task automatic model_apply(input logic [2:0] op, input int d);
      int t;
      case (op)
         LDA: begin m_a = d; m_z = (d == 0); m_n = (d >= 128); end
         LDB: m_b = d;
         CLC: m_c = 0;
         STA: m_res = m_a;
         default: begin
            if (op == ADD || op == ADC) begin
               t = m_a + m_b + ((op == ADC) ? m_c : 0);
               m_c = (t > 255);
            end else begin
               t = m_a - m_b - ((op == SBC) ? (1 - m_c) : 0);
               m_c = (t >= 0);
            end
            t = (t + 256) % 256;
            m_a = t; m_res = t; m_z = (t == 0); m_n = (t >= 128);
         end
      endcase
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_res = 0;
   endtask

   // Register state is architecturally visible whenever idle or responding.
   always @(negedge clk) begin
      if (!reset && (cmd_ready || res_valid)) begin
         chk("acc", acc_q, m_a);
         chk("breg", breg_q, m_b);
         chk("flag_c", flag_c, m_c);
         chk("flag_z", flag_z, m_z);
         chk("flag_n", flag_n, m_n);
         if (res_valid) begin
            chk("res_data", res_data, m_res);
            chk("ready_in_resp", cmd_ready, 0);
         end
      end
   end

   // Called just after a rising edge. hold = cycles of response backpressure;
   // pend = keep a second command (LDA 0x77) waiting during backpressure.
   task automatic issue(input logic [2:0] op, input int d, input int hold, input bit pend);
      int w;
      cmd_op = op; cmd_data = 8'(d); cmd_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 20) begin w++; @(negedge clk); end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      model_apply(op, d);
      if (op == LDA || op == LDB || op == CLC) return;
      for (int k = 1; k <= ((op == STA) ? 1 : 2); k++) begin
         @(negedge clk);
         chk("res_latency", res_valid, (k == ((op == STA) ? 1 : 2)) ? 1 : 0);
      end
      for (int h = 0; h < hold; h++) begin
         if (pend) begin cmd_op = LDA; cmd_data = 8'h77; cmd_valid = 1'b1; end
         @(negedge clk);
         chk("held_valid", res_valid, 1);
         chk("held_not_ready", cmd_ready, 0);
      end
      last_res = res_data;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_resp", cmd_ready, 1);
      chk("valid_after_resp", res_valid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] rop;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_acc", acc_q, 0);
      chk("rst_breg", breg_q, 0);
      chk("rst_flags", {flag_c, flag_z, flag_n}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      issue(LDA, 10, 0, 0); issue(LDB, 20, 0, 0); issue(ADD, 0, 0, 0);
      chk("add_10_20", last_res, 30);
      chk("add_10_20_czn", {flag_c, flag_z, flag_n}, 3'b000);

      issue(LDA, 255, 0, 0); issue(LDB, 1, 0, 0); issue(ADD, 0, 1, 0);
      chk("add_wrap", last_res, 0);
      chk("add_wrap_czn", {flag_c, flag_z, flag_n}, 3'b110);
      issue(ADC, 0, 0, 0);
      chk("adc_carry", last_res, 2);
      chk("adc_carry_c", flag_c, 0);

      issue(LDA, 50, 0, 0); issue(LDB, 10, 0, 0); issue(SUB, 0, 0, 0);
      chk("sub_50_10", last_res, 40);
      chk("sub_50_10_c", flag_c, 1);
      issue(LDA, 10, 0, 0); issue(LDB, 20, 0, 0); issue(SUB, 0, 0, 0);
      chk("sub_borrow", last_res, 246);
      chk("sub_borrow_cn", {flag_c, flag_n}, 2'b01);

      issue(CLC, 0, 0, 0); issue(LDA, 100, 0, 0); issue(LDB, 155, 0, 0);
      issue(ADC, 0, 0, 0);
      chk("adc_100_155", last_res, 255);
      chk("adc_100_155_cn", {flag_c, flag_n}, 2'b01);
      issue(STA, 0, 2, 0);
      chk("sta", last_res, 255);

      // Backpressure with a queued command waiting behind the response.
      issue(LDA, 10, 0, 0); issue(LDB, 20, 0, 0); issue(ADD, 0, 3, 1);
      chk("bp_add", last_res, 30);
      chk("bp_acc_kept", acc_q, 30);
      issue(LDA, 8'h77, 0, 0);

      // Reset during EXEC discards the operation.
      issue(LDA, 10, 0, 0); issue(LDB, 20, 0, 0);
      cmd_op = ADD; cmd_valid = 1'b1;
      @(negedge clk);
      chk("rst_exec_accept", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_exec_acc", acc_q, 0);
      chk("rst_exec_breg", breg_q, 0);
      chk("rst_exec_flags", {flag_c, flag_z, flag_n}, 0);
      chk("rst_exec_valid", res_valid, 0);
      chk("rst_exec_ready", cmd_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_resp", res_valid, 0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 400; i++) begin
         rop = 3'($urandom_range(0, 7));
         issue(rop, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
